// File: rtl/instruction_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder_if
//  Description : Field-bundle input handshake plus instruction-memory write
//                port of the instruction encoder. The slave modport is the
//                encoder's view; the master modport is the source/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instruction_encoder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            condition;
    logic [3:0]            op_code;
    logic [2:0]            dest_reg;
    logic [2:0]            source_reg_one;
    logic [2:0]            source_reg_two;
    logic [1:0]            bits_to_shift;
    logic                  mem_we;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_data;

    modport slave (
        input  in_valid, condition, op_code, dest_reg, source_reg_one,
               source_reg_two, bits_to_shift, mem_ready,
        output in_ready, mem_we, mem_addr, mem_data
    );

    modport master (
        output in_valid, condition, op_code, dest_reg, source_reg_one,
               source_reg_two, bits_to_shift, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_data
    );
endinterface
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder
//  Description : Packs instruction fields into 16-bit words
//                {cond, op[2:0], dest, src1, src2, shift} and streams one
//                load session of PROG_LEN words into instruction memory from
//                BASE_ADDR upward through a 2-entry output buffer.
//                Optional macro ENC_OPCODE_CHECK_EN: bundles with op_code[3]=1
//                are consumed but dropped, and set the sticky illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0,
    parameter int PROG_LEN   = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            start,
    instruction_encoder_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);
    // Counters must reach PROG_LEN, which may equal 2**ADDR_WIDTH.
    localparam int                    CW     = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         LEN_C  = CW'(PROG_LEN);
    localparam logic [ADDR_WIDTH-1:0] BASE_C = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic [15:0]           buf0_q, buf0_d;   // buffer head (the word on mem_data)
    logic [15:0]           buf1_q, buf1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         wr_q, wr_d;
    logic                  illegal_q, illegal_d;

    logic [15:0] word;
    logic        rdy, accept, push, bad, pop;

    assign word = {bus.condition, bus.op_code[2:0], bus.dest_reg,
                   bus.source_reg_one, bus.source_reg_two, bus.bits_to_shift};
    assign rdy    = (state_q == LOAD) && (count_q < 2'd2) && (acc_q < LEN_C);
    assign accept = bus.in_valid && rdy;
    assign pop    = (count_q != 2'd0) && bus.mem_ready;

`ifdef ENC_OPCODE_CHECK_EN
    // Reserved opcodes complete the handshake but never reach memory.
    assign push = accept && !bus.op_code[3];
    assign bad  = accept &&  bus.op_code[3];
`else
    // op_code[3] is simply dropped by the packing above.
    assign push = accept;
    assign bad  = 1'b0;
`endif

    // State register, buffer and counters; reset empties the buffer at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 2'd0;
            buf0_q    <= 16'd0;
            buf1_q    <= 16'd0;
            addr_q    <= BASE_C;
            acc_q     <= '0;
            wr_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buf0_q    <= buf0_d;
            buf1_q    <= buf1_d;
            addr_q    <= addr_d;
            acc_q     <= acc_d;
            wr_q      <= wr_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state: session control, FIFO push/pop, write address and counters.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf0_d    = buf0_q;
        buf1_d    = buf1_q;
        addr_d    = addr_q;
        acc_d     = acc_q;
        wr_d      = wr_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    count_d   = 2'd0;
                    addr_d    = BASE_C;
                    acc_d     = '0;
                    wr_d      = '0;
                    illegal_d = 1'b0;
                end
            end
            LOAD: begin
                // Head always holds the oldest word; buf1 only when count is 2.
                case ({push, pop})
                    2'b10: begin
                        if (count_q == 2'd0) buf0_d = word;
                        else                 buf1_d = word;
                        count_d = count_q + 2'd1;
                    end
                    2'b01: begin
                        buf0_d  = buf1_q;
                        count_d = count_q - 2'd1;
                    end
                    2'b11: begin
                        if (count_q == 2'd1) begin
                            buf0_d = word;
                        end else begin
                            buf0_d = buf1_q;
                            buf1_d = word;
                        end
                    end
                    default: ;
                endcase
                if (push) acc_d = acc_q + CW'(1);
                if (bad)  illegal_d = 1'b1;
                if (pop) begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    wr_d   = wr_q + CW'(1);
                    if (wr_q + CW'(1) == LEN_C) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready = rdy;
    assign bus.mem_we   = (count_q != 2'd0);
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = buf0_q;
    assign busy         = (state_q == LOAD);
    assign done         = (state_q == DONE);
    assign illegal      = illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_encoder
//  Description : Scoreboard bench for instruction_encoder. Directed bundles
//                with hand-computed words; a negedge monitor pops expected
//                {addr,data} on every completed memory write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_encoder;
    localparam int AW   = 8;
    localparam int BASE = 254;
    localparam int LEN  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, illegal;

    instruction_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    instruction_encoder #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .PROG_LEN  (LEN)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .done   (done),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] next_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed write must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && bus.mem_we && bus.mem_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.mem_addr, bus.mem_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_data), 32'(e.data));
            end
        end
    end

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        next_addr = AW'(BASE);
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] op, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [1:0] sh,
                        input logic [15:0] exp_word, input bit expect_write);
        int n = 0;
        bus.condition      = c;
        bus.op_code        = op;
        bus.dest_reg       = d;
        bus.source_reg_one = s1;
        bus.source_reg_two = s2;
        bus.bits_to_shift  = sh;
        bus.in_valid       = 1'b1;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (expect_write) begin
            sb.push_back({next_addr, exp_word});
            next_addr = next_addr + AW'(1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.mem_ready      = 1'b0;
        bus.condition      = 2'd0;
        bus.op_code        = 4'd0;
        bus.dest_reg       = 3'd0;
        bus.source_reg_one = 3'd0;
        bus.source_reg_two = 3'd0;
        bus.bits_to_shift  = 2'd0;
        next_addr          = AW'(BASE);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_mem_we",   32'(bus.mem_we),   32'd0);
        check("rst_addr",     32'(bus.mem_addr), 32'd254);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_illegal",  32'(illegal),      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Session 1: back-to-back, memory always ready, address wraps 255->0.
        bus.mem_ready = 1'b1;
        pulse_start();
        check("s1_busy", 32'(busy), 32'd1);
        send(2'd2, 4'd5, 3'd3, 3'd5, 3'd7, 2'd1, 16'hABBD, 1'b1);
        check("s1_latency_we",   32'(bus.mem_we),   32'd1);
        check("s1_latency_data", 32'(bus.mem_data), 32'hABBD);
        check("s1_latency_addr", 32'(bus.mem_addr), 32'd254);
        send(2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1);
        send(2'd3, 4'd7, 3'd7, 3'd7, 3'd7, 2'd3, 16'hFFFF, 1'b1);
        send(2'd1, 4'd2, 3'd4, 3'd1, 3'd6, 2'd2, 16'h543A, 1'b1);
        wait_done();
        check("s1_busy_low",   32'(busy),         32'd0);
        check("s1_in_ready",   32'(bus.in_ready), 32'd0);
        check("s1_sb_empty",   32'(sb.size()),    32'd0);
        // in_valid outside LOAD is ignored and done holds.
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("done_in_ready", 32'(bus.in_ready), 32'd0);
            check("done_held",     32'(done),         32'd1);
        end
        bus.in_valid = 1'b0;

        // Session 2: memory stalls; buffer fills, outputs hold, start ignored.
        bus.mem_ready = 1'b0;
        pulse_start();
        check("s2_done_cleared", 32'(done), 32'd0);
        send(2'd0, 4'd3, 3'd1, 3'd2, 3'd3, 2'd0, 16'h194C, 1'b1);
        send(2'd2, 4'd4, 3'd6, 3'd3, 3'd5, 2'd1, 16'hA675, 1'b1);
        check("s2_full_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            start = (i == 1);
            check("s2_stall_we",   32'(bus.mem_we),   32'd1);
            check("s2_stall_addr", 32'(bus.mem_addr), 32'd254);
            check("s2_stall_data", 32'(bus.mem_data), 32'h194C);
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("s2_busy", 32'(busy), 32'd1);
        bus.mem_ready = 1'b1;
        send(2'd3, 4'd1, 3'd0, 3'd7, 3'd0, 2'd2, 16'hC8E2, 1'b1);
        send(2'd1, 4'd6, 3'd5, 3'd4, 3'd2, 2'd0, 16'h7588, 1'b1);
        wait_done();
        check("s2_sb_empty", 32'(sb.size()), 32'd0);

        // Session 3: reset with two words buffered discards them.
        bus.mem_ready = 1'b0;
        pulse_start();
        send(2'd2, 4'd5, 3'd3, 3'd5, 3'd7, 2'd1, 16'hABBD, 1'b1);
        send(2'd0, 4'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0000, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        check("midrst_mem_we", 32'(bus.mem_we),   32'd0);
        check("midrst_busy",   32'(busy),         32'd0);
        check("midrst_addr",   32'(bus.mem_addr), 32'd254);
        check("midrst_done",   32'(done),         32'd0);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        check("postrst_mem_we", 32'(bus.mem_we), 32'd0);

        // Session 4: reserved opcode bit.
        pulse_start();
`ifdef ENC_OPCODE_CHECK_EN
        send(2'd1, 4'b1001, 3'd2, 3'd4, 3'd6, 2'd3, 16'h4A9B, 1'b0);
        check("rsv_illegal", 32'(illegal),    32'd1);
        check("rsv_no_we",   32'(bus.mem_we), 32'd0);
        @(posedge clk); #1;
        check("rsv_illegal_sticky", 32'(illegal),    32'd1);
        check("rsv_no_we_later",    32'(bus.mem_we), 32'd0);
`else
        send(2'd1, 4'b1001, 3'd2, 3'd4, 3'd6, 2'd3, 16'h4A9B, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rsv_illegal_tied", 32'(illegal), 32'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
